// File: rtl/regfile_seq_pkg.sv
// rtl/regfile_seq_pkg.sv - shared opcodes, FSM states and width defaults for regfile_sequencer
package regfile_seq_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int AW_DEFAULT = 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_LDI  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// rtl/regfile_seq_alu.sv - combinational ALU for regfile_sequencer
// REGFILE_SEQ_SAT_EN: ADD/ADDI clamp high on carry, SUB clamps to zero on borrow.
module regfile_seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          carry
);

  logic [DW:0] sum_ab;
  logic [DW:0] diff_ab;
  logic [DW:0] sum_ai;

  assign sum_ab  = {1'b0, a} + {1'b0, b};
  assign diff_ab = {1'b0, a} - {1'b0, b};
  assign sum_ai  = {1'b0, a} + {1'b0, imm};

  // carry always reports the raw carry/borrow, even when the result is clamped
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum_ab[DW-1:0];
        carry  = sum_ab[DW];
`ifdef REGFILE_SEQ_SAT_EN
        if (sum_ab[DW]) result = '1;
`endif
      end
      OP_SUB: begin
        result = diff_ab[DW-1:0];
        carry  = diff_ab[DW];
`ifdef REGFILE_SEQ_SAT_EN
        if (diff_ab[DW]) result = '0;
`endif
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = {{(DW-1){1'b0}}, (a < b)};
      OP_LDI:  result = imm;
      OP_ADDI: begin
        result = sum_ai[DW-1:0];
        carry  = sum_ai[DW];
`ifdef REGFILE_SEQ_SAT_EN
        if (sum_ai[DW]) result = '1;
`endif
      end
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - instruction sequencer driving the 8x8 register file
// Optional ALU saturation selected by REGFILE_SEQ_SAT_EN.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic [DW-1:0] imm,
  output logic          WEN,
  output logic [AW-1:0] RW,
  output logic [DW-1:0] busW,
  output logic [AW-1:0] RX,
  output logic [AW-1:0] RY,
  input  logic [DW-1:0] busX,
  input  logic [DW-1:0] busY,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_zero,
  output logic          out_carry
);

  state_e        state_q, state_d;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q, rs_q, rt_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] result_q;
  logic          zero_q, carry_q;
  logic          in_ready_q, in_ready_d;
  logic          wen_q, wen_d;
  logic          out_valid_q, out_valid_d;
  logic          capture_en, result_en;

  logic [DW-1:0] alu_result;
  logic          alu_zero, alu_carry;

  regfile_seq_alu #(.DW(DW)) u_alu (
    .op     (op_q),
    .a      (busX),
    .b      (busY),
    .imm    (imm_q),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  always_comb begin
    state_d    = state_q;
    capture_en = 1'b0;
    result_en  = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (in_valid) begin
          state_d    = ST_EXEC;
          capture_en = 1'b1;
        end
      end
      ST_EXEC: begin
        state_d   = ST_WB;
        result_en = 1'b1;
      end
      ST_WB:   state_d = ST_RESP;
      ST_RESP: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
    // outputs are decoded from the next state so they register alongside it
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_RESP);
    wen_d       = (state_d == ST_WB) && (rd_q != '0);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_INIT;
      op_q        <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      imm_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      wen_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      wen_q       <= wen_d;
      out_valid_q <= out_valid_d;
      if (capture_en) begin
        op_q  <= op;
        rd_q  <= rd;
        rs_q  <= rs;
        rt_q  <= rt;
        imm_q <= imm;
      end
      if (result_en) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
        carry_q  <= alu_carry;
      end
    end
  end

  // read/write addresses only change at accept, so they hold between instructions
  assign RX        = rs_q;
  assign RY        = rt_q;
  assign RW        = rd_q;
  assign WEN       = wen_q;
  assign busW      = result_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = result_q;
  assign out_zero  = zero_q;
  assign out_carry = carry_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - self-checking bench for regfile_sequencer with a register file model
module tb_regfile_sequencer;

`ifdef REGFILE_SEQ_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Rst;
  logic       in_valid, in_ready;
  logic [2:0] op, rd, rs, rt;
  logic [7:0] imm;
  logic       WEN;
  logic [2:0] RW, RX, RY;
  logic [7:0] busW, busX, busY;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_zero, out_carry;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int last_accept = 0;
  logic       rf_init;
  logic [7:0] rf [8];
  int         ref_rf [8];

  regfile_sequencer dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .WEN(WEN), .RW(RW), .busW(busW), .RX(RX), .RY(RY),
    .busX(busX), .busY(busY), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_carry(out_carry)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // register file: r0 reads as zero, first edge clears storage
  always @(posedge Clk) begin
    if (rf_init) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else if (WEN && RW != 3'd0) begin
      rf[RW] <= busW;
    end
  end
  assign busX = (RX == 3'd0) ? 8'h00 : rf[RX];
  assign busY = (RY == 3'd0) ? 8'h00 : rf[RY];

  function automatic void model(input int o, input int a, input int b, input int im,
                                output int r, output int c);
    int s;
    c = 0;
    r = 0;
    case (o)
      0: begin s = a + b; c = (s > 255) ? 1 : 0; r = s % 256; if (SAT && c == 1) r = 255; end
      1: begin s = a - b; c = (a < b) ? 1 : 0; r = (s + 256) % 256; if (SAT && c == 1) r = 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a < b) ? 1 : 0;
      6: r = im;
      default: begin s = a + im; c = (s > 255) ? 1 : 0; r = s % 256; if (SAT && c == 1) r = 255; end
    endcase
  endfunction

  task automatic run_instr(input int o, input int d, input int s, input int t, input int im,
                           input int stall, output logic [7:0] got, output logic got_z,
                           output logic got_c);
    int exp_r, exp_c;
    logic [7:0] held;
    model(o, ref_rf[s], ref_rf[t], im, exp_r, exp_c);
    for (int i = 0; i < 20 && in_ready !== 1'b1; i++) @(negedge Clk);
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_ready got %b exp 1 (timeout)", in_ready);
    end
    out_ready = (stall == 0);
    op = 3'(o); rd = 3'(d); rs = 3'(s); rt = 3'(t); imm = 8'(im);
    in_valid = 1'b1;
    @(posedge Clk);
    #1;
    last_accept = cyc;
    in_valid = 1'b0;
    op = 3'($urandom); rd = 3'($urandom); rs = 3'($urandom); rt = 3'($urandom); imm = 8'($urandom);
    @(negedge Clk);
    tests_run++;
    if ({RX, RY, WEN, in_ready, out_valid} !== {3'(s), 3'(t), 3'b000}) begin
      tests_failed++;
      $display("FAIL exec_state got RX=%0d RY=%0d WEN=%b rdy=%b ov=%b exp RX=%0d RY=%0d 0 0 0",
               RX, RY, WEN, in_ready, out_valid, s, t);
    end
    @(negedge Clk);
    tests_run++;
    if (WEN !== (d != 0) || RW !== 3'(d) || busW !== 8'(exp_r)) begin
      tests_failed++;
      $display("FAIL wb_write got WEN=%b RW=%0d busW=%h exp WEN=%b RW=%0d busW=%h",
               WEN, RW, busW, (d != 0), d, exp_r);
    end
    @(negedge Clk);
    got = out_data; got_z = out_zero; got_c = out_carry; held = out_data;
    tests_run++;
    if (out_valid !== 1'b1 || WEN !== 1'b0 || out_data !== 8'(exp_r) ||
        out_zero !== (exp_r == 0) || out_carry !== 1'(exp_c)) begin
      tests_failed++;
      $display("FAIL resp got ov=%b WEN=%b data=%h z=%b c=%b exp ov=1 WEN=0 data=%h z=%b c=%0d",
               out_valid, WEN, out_data, out_zero, out_carry, exp_r, (exp_r == 0), exp_c);
    end
    if (d != 0) ref_rf[d] = exp_r;
    repeat (stall) begin
      @(negedge Clk);
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold got ov=%b data=%h rdy=%b exp ov=1 data=%h rdy=0",
                 out_valid, out_data, in_ready, held);
      end
    end
    out_ready = 1'b1;
    @(negedge Clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL release got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; rf_init = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'd0; rd = 3'd0; rs = 3'd0; rt = 3'd0; imm = 8'd0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 0;
    repeat (2) @(negedge Clk);
    tests_run++;
    if ({in_ready, WEN, RW, busW, RX, RY, out_valid, out_data, out_zero, out_carry} !== 38'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got rdy=%b WEN=%b RW=%0d busW=%h RX=%0d RY=%0d ov=%b data=%h z=%b c=%b exp all 0",
               in_ready, WEN, RW, busW, RX, RY, out_valid, out_data, out_zero, out_carry);
    end
    Rst = 1'b0; rf_init = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL init_not_ready got %b exp 0", in_ready);
    end
    @(negedge Clk);
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_ldi();
    logic [7:0] g; logic z, c;
    run_instr(6, 3, 0, 0, 'h5A, 0, g, z, c);
    tests_run++;
    if (g !== 8'h5A || z !== 1'b0) begin
      tests_failed++;
      $display("FAIL ldi_r3 got %h z=%b exp 5a z=0", g, z);
    end
  endtask

  task automatic test_add_sub();
    logic [7:0] g; logic z, c;
    run_instr(6, 1, 0, 0, 'hF0, 0, g, z, c);
    run_instr(6, 2, 0, 0, 'h20, 0, g, z, c);
    run_instr(0, 4, 1, 2, 0, 0, g, z, c);
    tests_run++;
    if (g !== (SAT ? 8'hFF : 8'h10) || c !== 1'b1) begin
      tests_failed++;
      $display("FAIL add_r4 got %h c=%b exp %h c=1", g, c, (SAT ? 8'hFF : 8'h10));
    end
    run_instr(3, 7, 4, 4, 0, 0, g, z, c);
    tests_run++;
    if (g !== (SAT ? 8'hFF : 8'h10)) begin
      tests_failed++;
      $display("FAIL readback_r4 got %h exp %h", g, (SAT ? 8'hFF : 8'h10));
    end
    run_instr(1, 5, 2, 1, 0, 0, g, z, c);
    tests_run++;
    if (g !== (SAT ? 8'h00 : 8'h30) || c !== 1'b1 || z !== SAT) begin
      tests_failed++;
      $display("FAIL sub_r5 got %h c=%b z=%b exp %h c=1 z=%b", g, c, z, (SAT ? 8'h00 : 8'h30), SAT);
    end
  endtask

  task automatic test_r0();
    logic [7:0] g; logic z, c;
    run_instr(6, 0, 0, 0, 'h77, 0, g, z, c);
    tests_run++;
    if (g !== 8'h77) begin
      tests_failed++;
      $display("FAIL ldi_r0 got %h exp 77", g);
    end
    run_instr(3, 6, 0, 0, 0, 0, g, z, c);
    tests_run++;
    if (g !== 8'h00 || z !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_r0 got %h z=%b exp 00 z=1", g, z);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g; logic z, c;
    logic [7:0] exp_v [5];
    logic       exp_c [5];
    int prev;
    exp_v = SAT ? '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF} : '{8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
    exp_c = SAT ? '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1} : '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    run_instr(6, 1, 0, 0, 'hFE, 0, g, z, c);
    prev = last_accept;
    for (int i = 0; i < 5; i++) begin
      run_instr(7, 1, 1, 0, 1, 0, g, z, c);
      tests_run++;
      if (g !== exp_v[i] || c !== exp_c[i] || last_accept - prev != 4) begin
        tests_failed++;
        $display("FAIL chain_%0d got %h c=%b gap=%0d exp %h c=%b gap=4",
                 i, g, c, last_accept - prev, exp_v[i], exp_c[i]);
      end
      prev = last_accept;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] g; logic z, c;
    run_instr(4, 3, 1, 2, 0, 6, g, z, c);
    run_instr(5, 2, 2, 1, 0, 6, g, z, c);
  endtask

  task automatic test_reset_in_wb();
    logic [7:0] g; logic z, c;
    run_instr(6, 5, 0, 0, 'h3C, 0, g, z, c);
    op = 3'd6; rd = 3'd5; rs = 3'd0; rt = 3'd0; imm = 8'hC3; in_valid = 1'b1;
    @(posedge Clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge Clk);
    tests_run++;
    if (WEN !== 1'b1) begin
      tests_failed++;
      $display("FAIL wb_before_rst got WEN=%b exp 1", WEN);
    end
    Rst = 1'b1;
    #1;
    tests_run++;
    if (WEN !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_in_wb got WEN=%b ov=%b rdy=%b exp 0 0 0", WEN, out_valid, in_ready);
    end
    @(negedge Clk);
    Rst = 1'b0;
    run_instr(3, 6, 5, 5, 0, 0, g, z, c);
    tests_run++;
    if (g !== 8'h3C) begin
      tests_failed++;
      $display("FAIL r5_after_rst got %h exp 3c", g);
    end
  endtask

  task automatic test_random();
    logic [7:0] g; logic z, c;
    for (int i = 0; i < 40; i++) begin
      run_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 2)),
                g, z, c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ldi();
    test_add_sub();
    test_r0();
    test_back_to_back();
    test_backpressure();
    test_reset_in_wb();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Instruction sequencer that drives the 8×8-bit register file as its write/read initiator. It accepts one three-operand instruction per handshake and reads the two source registers through the file's combinational read ports. It computes an 8-bit ALU result, writes it back through the single write port, and returns the result plus flags to the requester. It sits between the top-level testbench/decoder and the register file, and owns every `WEN/RW/busW/RX/RY` driver.

## Interface
- `DW`, default 8: data width; must match the register file.
- `AW`, default 3: register address width, giving 8 registers.
- `Clk` in 1: rising-edge clock, shared with the register file.
- `Rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: sequencer can accept an instruction.
- `op` in 3: opcode.
- `rd` in AW: destination register.
- `rs` in AW: source register X.
- `rt` in AW: source register Y.
- `imm` in DW: immediate operand for LDI/ADDI.
- `WEN` out 1: register-file write enable.
- `RW` out AW: write address.
- `busW` out DW: write data.
- `RX` out AW: read address X.
- `RY` out AW: read address Y.
- `busX` in DW: read data X.
- `busY` in DW: read data Y.
- `out_valid` out 1: result available.
- `out_ready` in 1: requester accepts the result.
- `out_data` out DW: ALU result.
- `out_zero` out 1: result equals 0.
- `out_carry` out 1: carry/borrow from ADD/SUB/ADDI; 0 for all other ops.

## Operation
- Opcodes:
  - 000 ADD: rs+rt
  - 001 SUB: rs−rt
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: unsigned rs<rt → 1, else 0
  - 110 LDI: imm
  - 111 ADDI: rs+imm
- Arithmetic is DW bits, modulo 2^DW. Carry is bit DW of the DW+1-bit sum. For SUB, carry=1 means borrow (rs<rt).
- FSM states:
  - INIT: in_ready=0.
  - IDLE: in_ready=1.
  - EXEC: RX=rs_q, RY=rt_q; busX/busY sampled, ALU result and flags registered.
  - WB: WEN=1 unless rd_q==0; RW=rd_q, busW=result.
  - RESP: out_valid=1.
- Transitions:
  - INIT→IDLE unconditionally after one cycle. This covers the register file's first-edge self-clear.
  - IDLE→EXEC on in_valid&&in_ready; op/rd/rs/rt/imm captured at that edge.
  - EXEC→WB.
  - WB→RESP.
  - RESP→IDLE on out_ready. Otherwise hold, with out_data/flags stable.
- rd==0: no write is issued (WEN stays 0), but the result is still returned.
- RX/RY hold their last values outside EXEC. WEN=0 in every state except WB.
- Back-to-back dependency (rd of instruction n == rs of n+1) is inherently safe: the write lands at the WB→RESP edge, at least two cycles before the next EXEC.

## Timing
- Reset values: in_ready=0, WEN=0, RW=0, busW=0, RX=0, RY=0, out_valid=0, out_data=0, out_zero=0, out_carry=0; state=INIT.
- Rst asserted mid-operation: outputs clear immediately (asynchronous), the pending write is dropped, and the in-flight instruction is lost.
- Latency from the accept edge:
  - EXEC cycle 1.
  - WEN high during cycle 2.
  - out_valid high from cycle 3.
  - Minimum 4 cycles per instruction with out_ready held high.
- in_ready is high only in IDLE. in_valid in any other state is ignored.
- out_valid, once high, stays high with stable data until the out_ready edge.
- All outputs are registered; none combinationally depend on in_valid or out_ready.

## Configuration
- `REGFILE_SEQ_SAT_EN` defined:
  - ADD/ADDI clamp to 2^DW−1 on carry.
  - SUB clamps to 0 on borrow.
  - out_carry still reports the unsaturated carry/borrow.
- Undefined: plain modulo wrap.
- No other behaviour differs.

## Structure
- Shared package `regfile_seq_pkg`: opcode constants (OP_ADD…OP_ADDI), FSM state encodings, DW/AW defaults.
- Sub-module `regfile_seq_alu`: purely combinational ALU taking op, a, b, imm and producing result, zero and carry. It contains the saturation logic under the macro.
- The top holds the FSM, the instruction capture registers and the output registers.

## Test plan
- Reset, then LDI r3←0x5A: WEN=1, RW=3, busW=0x5A two cycles after accept; out_data=0x5A, zero=0.
- r1=0xF0, r2=0x20, ADD r4←r1+r2: wrap build gives out_data=0x10, carry=1; `REGFILE_SEQ_SAT_EN` build gives 0xFF, carry=1. r4 reads back accordingly.
- SUB r5←r2−r1 (0x20−0xF0): wrap build gives 0x30, carry=1; sat build gives 0x00, zero=1.
- LDI r0←0x77: WEN never asserts, out_data=0x77, and a later MOV-style read of r0 (OR r6←r0|r0) returns 0x00, zero=1.
- Dependent chain ADDI r1←r1+1 issued 5× with out_ready=1 from r1=0xFE: results FF,00,01,02,03; exactly 4 cycles per instruction; carry=1 only on the second.
- Backpressure: out_ready=0 for 6 cycles in RESP keeps out_valid/out_data stable and in_ready=0. Rst pulsed during WB leaves WEN low immediately and the target register unchanged.
